// File: rtl/rtc_calendar_core_if.sv
// rtc_calendar_core_if
//   Bundles the key pulses, alarm configuration and the binary time/calendar
//   fields that pass between the key debouncers, the calendar core and the
//   display mux.
//
//   Signals
//     mode_next    1  pulse: advance to the next set field / back to RUN
//     key_inc      1  pulse: increment the selected field
//     key_dec      1  pulse: decrement the selected field
//     alarm_en     1  daily alarm enable
//     alarm_hour   5  alarm hour 0..23
//     alarm_min    6  alarm minute 0..59
//     second       6  0..59
//     minute       6  0..59
//     hour         5  0..23
//     day          5  1..days in month
//     month        4  1..12
//     year         7  0..99 (offset from 2000)
//     field_sel    3  0=RUN,1=HOUR,2=MIN,3=YEAR,4=MONTH,5=DAY
//     running      1  high while counting time
//     sec_pulse    1  one cycle high when a new second appears
//     alarm_pulse  1  one cycle high when the alarm time is reached
//
//   Modports
//     master  key/alarm source and field consumer (debouncers + display side)
//     slave   the calendar core itself
interface rtc_calendar_core_if;
  logic       mode_next;
  logic       key_inc;
  logic       key_dec;
  logic       alarm_en;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [5:0] second;
  logic [5:0] minute;
  logic [4:0] hour;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic [2:0] field_sel;
  logic       running;
  logic       sec_pulse;
  logic       alarm_pulse;

  modport master (
    output mode_next, key_inc, key_dec, alarm_en, alarm_hour, alarm_min,
    input  second, minute, hour, day, month, year,
    input  field_sel, running, sec_pulse, alarm_pulse
  );

  modport slave (
    input  mode_next, key_inc, key_dec, alarm_en, alarm_hour, alarm_min,
    output second, minute, hour, day, month, year,
    output field_sel, running, sec_pulse, alarm_pulse
  );
endinterface

// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core
//   Time-of-day and calendar core: hh:mm:ss plus day/month/year for the
//   years 2000..2099 with leap-year February, a per-field set mode driven by
//   inc/dec/mode key pulses, and a daily hh:mm alarm. Every output is a
//   register; nothing from the key inputs reaches an output combinationally.
//
//   Parameters
//     TICKS_PER_SEC  clock cycles per second (>= 2)
//     PRESC_W        prescaler width, must hold TICKS_PER_SEC-1
//
//   Ports
//     clock  in  system clock
//     reset  in  synchronous active-high reset, wins over every input
//     bus    slave side of rtc_calendar_core_if (keys, alarm, fields out)
module rtc_calendar_core #(
  parameter int TICKS_PER_SEC = 32768,
  parameter int PRESC_W       = 15
) (
  input logic              clock,
  input logic              reset,
  rtc_calendar_core_if.slave bus
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_HOUR  = 3'd1,
    SET_MIN   = 3'd2,
    SET_YEAR  = 3'd3,
    SET_MONTH = 3'd4,
    SET_DAY   = 3'd5
  } state_t;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  state_t state;
  state_t state_next;

  logic [PRESC_W-1:0] presc;
  logic [5:0]         second_q;
  logic [5:0]         minute_q;
  logic [4:0]         hour_q;
  logic [4:0]         day_q;
  logic [3:0]         month_q;
  logic [6:0]         year_q;
  logic               running_q;
  logic               sec_pulse_q;
  logic               alarm_pulse_q;

  logic [4:0] dim;
  logic       tick;
  logic       sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap;
  logic [5:0] second_n;
  logic [5:0] minute_n;
  logic [4:0] hour_n;
  logic [4:0] day_n;
  logic [3:0] month_n;
  logic [6:0] year_n;
  logic       alarm_hit;
  logic       edit_up;
  logic       edit_any;

  // Days in month; the century year 2000 is a leap year, so year[1:0]==0
  // alone decides February across 2000..2099.
  function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                               input logic [6:0] y);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  // One wrapping step inside lo..hi, used for every editable field.
  function automatic logic [6:0] wrap_step(input logic [6:0] val,
                                           input logic [6:0] lo,
                                           input logic [6:0] hi,
                                           input logic       up);
    logic [6:0] r;
    if (up) r = (val >= hi) ? lo : val + 7'd1;
    else    r = (val <= lo) ? hi : val - 7'd1;
    return r;
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Mode key walks the field ring; any other input leaves the state alone.
  always_comb begin
    state_next = state;
    if (bus.mode_next) begin
      case (state)
        RUN:       state_next = SET_HOUR;
        SET_HOUR:  state_next = SET_MIN;
        SET_MIN:   state_next = SET_YEAR;
        SET_YEAR:  state_next = SET_MONTH;
        SET_MONTH: state_next = SET_DAY;
        SET_DAY:   state_next = RUN;
        default:   state_next = RUN;
      endcase
    end
  end

  // Next values for a one-second advance with the full carry chain, so that
  // every field rolls over on the same edge.
  always_comb begin
    dim        = days_in_month(month_q, year_q);
    tick       = (state == RUN) && (presc == PRESC_MAX);
    sec_wrap   = (second_q == 6'd59);
    min_wrap   = sec_wrap && (minute_q == 6'd59);
    hour_wrap  = min_wrap && (hour_q == 5'd23);
    day_wrap   = hour_wrap && (day_q >= dim);
    month_wrap = day_wrap && (month_q == 4'd12);

    second_n = sec_wrap ? 6'd0 : second_q + 6'd1;
    minute_n = min_wrap ? 6'd0 : (sec_wrap ? minute_q + 6'd1 : minute_q);
    hour_n   = hour_wrap ? 5'd0 : (min_wrap ? hour_q + 5'd1 : hour_q);
    day_n    = day_wrap ? 5'd1 : (hour_wrap ? day_q + 5'd1 : day_q);
    month_n  = month_wrap ? 4'd1 : (day_wrap ? month_q + 4'd1 : month_q);
    year_n   = year_q;
    if (month_wrap) year_n = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;

    alarm_hit = bus.alarm_en && (hour_n == bus.alarm_hour) &&
                (minute_n == bus.alarm_min) && (second_n == 6'd0);

    // Simultaneous inc and dec cancel out.
    edit_any = bus.key_inc ^ bus.key_dec;
    edit_up  = bus.key_inc;
  end

  // Time/calendar registers: count in RUN, edit the selected field in the
  // set states. The day clamp sits last so it overrides everything and
  // repairs an out-of-range day one edge after a month/year change.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc         <= '0;
      second_q      <= 6'd0;
      minute_q      <= 6'd0;
      hour_q        <= 5'd0;
      day_q         <= 5'd1;
      month_q       <= 4'd1;
      year_q        <= 7'd0;
      running_q     <= 1'b1;
      sec_pulse_q   <= 1'b0;
      alarm_pulse_q <= 1'b0;
    end else begin
      running_q     <= (state_next == RUN);
      sec_pulse_q   <= tick;
      alarm_pulse_q <= tick && alarm_hit;

      if (state == RUN) begin
        if (tick) begin
          presc    <= '0;
          second_q <= second_n;
          minute_q <= minute_n;
          hour_q   <= hour_n;
          day_q    <= day_n;
          month_q  <= month_n;
          year_q   <= year_n;
        end else begin
          presc <= presc + PRESC_W'(1);
        end
      end else begin
        presc <= '0;
        if (edit_any) begin
          case (state)
            SET_HOUR:  hour_q   <= 5'(wrap_step({2'b0, hour_q}, 7'd0, 7'd23, edit_up));
            SET_MIN:   minute_q <= 6'(wrap_step({1'b0, minute_q}, 7'd0, 7'd59, edit_up));
            SET_YEAR:  year_q   <= wrap_step(year_q, 7'd0, 7'd99, edit_up);
            SET_MONTH: month_q  <= 4'(wrap_step({3'b0, month_q}, 7'd1, 7'd12, edit_up));
            SET_DAY:   day_q    <= 5'(wrap_step({2'b0, day_q}, 7'd1, {2'b0, dim}, edit_up));
            default:   ;
          endcase
        end
        // Leaving set mode restarts the second from a clean boundary.
        if ((state == SET_DAY) && bus.mode_next) second_q <= 6'd0;
      end

      if (day_q > dim) day_q <= dim;
    end
  end

  assign bus.second      = second_q;
  assign bus.minute      = minute_q;
  assign bus.hour        = hour_q;
  assign bus.day         = day_q;
  assign bus.month       = month_q;
  assign bus.year        = year_q;
  assign bus.field_sel   = state;
  assign bus.running     = running_q;
  assign bus.sec_pulse   = sec_pulse_q;
  assign bus.alarm_pulse = alarm_pulse_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// tb_rtc_calendar_core
//   Directed bench for rtc_calendar_core with a 4-cycle second. Inputs change
//   on the falling edge, outputs are sampled on the falling edge, and every
//   expected value is a hand-computed constant.
module tb_rtc_calendar_core;

  logic clock;
  logic reset;
  int   checks_total;
  int   checks_passed;

  rtc_calendar_core_if bus_if ();

  rtc_calendar_core #(
    .TICKS_PER_SEC(4),
    .PRESC_W      (2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  // 10-unit clock period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input int got, input int expected);
    checks_total++;
    if (got == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expected);
  endtask

  // Drives one key combination for exactly one rising edge.
  task automatic applyStimulus(input logic m, input logic inc, input logic dec);
    @(negedge clock);
    bus_if.mode_next = m;
    bus_if.key_inc   = inc;
    bus_if.key_dec   = dec;
    @(negedge clock);
    bus_if.mode_next = 1'b0;
    bus_if.key_inc   = 1'b0;
    bus_if.key_dec   = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset            = 1'b1;
    bus_if.mode_next = 1'b0;
    bus_if.key_inc   = 1'b0;
    bus_if.key_dec   = 1'b0;
    runCycles(2);
    reset = 1'b0;
  endtask

  // From reset values, walks through every set field with inc presses and
  // returns to RUN with second and prescaler at zero.
  task automatic setAll(input int h, input int m, input int y, input int mo, input int d);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (h) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (m) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (y) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (mo - 1) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (d - 1) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    checks_total      = 0;
    checks_passed     = 0;
    reset             = 1'b1;
    bus_if.mode_next  = 1'b0;
    bus_if.key_inc    = 1'b0;
    bus_if.key_dec    = 1'b0;
    bus_if.alarm_en   = 1'b0;
    bus_if.alarm_hour = 5'd7;
    bus_if.alarm_min  = 6'd30;

    // Reset values and first second.
    doReset();
    checkOutput("rst_second", int'(bus_if.second), 0);
    checkOutput("rst_hour", int'(bus_if.hour), 0);
    checkOutput("rst_day", int'(bus_if.day), 1);
    checkOutput("rst_month", int'(bus_if.month), 1);
    checkOutput("rst_year", int'(bus_if.year), 0);
    checkOutput("rst_running", int'(bus_if.running), 1);
    checkOutput("rst_field", int'(bus_if.field_sel), 0);
    checkOutput("rst_secpulse", int'(bus_if.sec_pulse), 0);
    runCycles(3);
    checkOutput("pre_tick_second", int'(bus_if.second), 0);
    checkOutput("pre_tick_pulse", int'(bus_if.sec_pulse), 0);
    runCycles(1);
    checkOutput("tick_second", int'(bus_if.second), 1);
    checkOutput("tick_pulse", int'(bus_if.sec_pulse), 1);
    runCycles(1);
    checkOutput("pulse_one_cycle", int'(bus_if.sec_pulse), 0);

    // Full rollover 23:59:59 31/12/99 -> 00:00:00 1/1/00.
    doReset();
    setAll(23, 59, 99, 12, 31);
    checkOutput("exit_running", int'(bus_if.running), 1);
    checkOutput("exit_second", int'(bus_if.second), 0);
    runCycles(236);
    checkOutput("roll_pre_second", int'(bus_if.second), 59);
    runCycles(3);
    checkOutput("roll_hold_day", int'(bus_if.day), 31);
    checkOutput("roll_hold_year", int'(bus_if.year), 99);
    runCycles(1);
    checkOutput("roll_second", int'(bus_if.second), 0);
    checkOutput("roll_minute", int'(bus_if.minute), 0);
    checkOutput("roll_hour", int'(bus_if.hour), 0);
    checkOutput("roll_day", int'(bus_if.day), 1);
    checkOutput("roll_month", int'(bus_if.month), 1);
    checkOutput("roll_year", int'(bus_if.year), 0);
    checkOutput("roll_pulse", int'(bus_if.sec_pulse), 1);

    // February in a leap year and a common year.
    doReset();
    setAll(23, 59, 24, 2, 28);
    runCycles(240);
    checkOutput("leap_day", int'(bus_if.day), 29);
    checkOutput("leap_month", int'(bus_if.month), 2);
    checkOutput("leap_hour", int'(bus_if.hour), 0);
    doReset();
    setAll(23, 59, 25, 2, 28);
    runCycles(240);
    checkOutput("common_day", int'(bus_if.day), 1);
    checkOutput("common_month", int'(bus_if.month), 3);
    checkOutput("common_year", int'(bus_if.year), 25);

    // Day clamp, frozen second in set mode, hour wrap, inc+dec cancel.
    doReset();
    setAll(0, 0, 24, 1, 31);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("clamp_field", int'(bus_if.field_sel), 4);
    runCycles(8);
    checkOutput("set_second_frozen", int'(bus_if.second), 0);
    checkOutput("set_no_pulse", int'(bus_if.sec_pulse), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("clamp_month", int'(bus_if.month), 2);
    checkOutput("clamp_day_before", int'(bus_if.day), 31);
    runCycles(1);
    checkOutput("clamp_day_after", int'(bus_if.day), 29);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hour_field", int'(bus_if.field_sel), 1);
    checkOutput("hour_not_running", int'(bus_if.running), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("hour_dec_wrap", int'(bus_if.hour), 23);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("hour_both_keys", int'(bus_if.hour), 23);

    // Alarm enabled and disabled.
    doReset();
    bus_if.alarm_en = 1'b1;
    setAll(7, 29, 0, 1, 1);
    runCycles(236);
    checkOutput("alarm_early", int'(bus_if.alarm_pulse), 0);
    runCycles(4);
    checkOutput("alarm_minute", int'(bus_if.minute), 30);
    checkOutput("alarm_fire", int'(bus_if.alarm_pulse), 1);
    runCycles(1);
    checkOutput("alarm_one_cycle", int'(bus_if.alarm_pulse), 0);
    doReset();
    bus_if.alarm_en = 1'b0;
    setAll(7, 29, 0, 1, 1);
    runCycles(240);
    checkOutput("alarm_dis_minute", int'(bus_if.minute), 30);
    checkOutput("alarm_disabled", int'(bus_if.alarm_pulse), 0);

    // Reset in the middle of set mode.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("midset_field", int'(bus_if.field_sel), 3);
    checkOutput("midset_year", int'(bus_if.year), 5);
    checkOutput("midset_hour", int'(bus_if.hour), 3);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midrst_field", int'(bus_if.field_sel), 0);
    checkOutput("midrst_running", int'(bus_if.running), 1);
    checkOutput("midrst_year", int'(bus_if.year), 0);
    checkOutput("midrst_hour", int'(bus_if.hour), 0);
    checkOutput("midrst_day", int'(bus_if.day), 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
